// File: rtl/stream_mux_rr.sv
// Round-robin / fixed-priority CH:1 stream mux with a registered output stage (optional packet lock: STREAM_MUX_PKT_LOCK_EN).
// Latency: 1 cycle from input transfer to OUT_VALID; 1 beat per cycle while OUT_READY=1.
// Backpressure: IN_READY of the granted channel follows load_en (!OUT_VALID || OUT_READY); all others are 0.
module stream_mux_rr #(
    parameter int N  = 4,
    parameter int CH = 4,
    parameter int SW = $clog2(CH)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            MODE,
    input  logic [CH*N-1:0] IN_DATA,
    input  logic [CH-1:0]   IN_VALID,
    output logic [CH-1:0]   IN_READY,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [CH-1:0]   IN_LAST,
    output logic            OUT_LAST,
`endif
    output logic [N-1:0]    OUT_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SW-1:0]   OUT_SEL
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [SW-1:0] fp_gnt;
    logic          fp_vld;
    logic [SW-1:0] rr_gnt;
    logic          rr_vld;
    logic [SW:0]   idx;
    logic [SW-1:0] gnt;
    logic          gnt_vld;
    logic          load_en;
    logic          xfer;
    logic [N-1:0]  gnt_dat;

    // Descending scans so the last write is the lowest index / smallest offset from ptr.
    always_comb begin
        fp_vld = 1'b0;
        fp_gnt = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (IN_VALID[i]) begin
                fp_vld = 1'b1;
                fp_gnt = SW'(i);
            end
        end
    end

    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        idx    = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (SW+1)'(i);
            if (idx >= (SW+1)'(CH))
                idx = idx - (SW+1)'(CH);
            if (IN_VALID[idx[SW-1:0]]) begin
                rr_vld = 1'b1;
                rr_gnt = idx[SW-1:0];
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic          locked;
    logic [SW-1:0] lock_ch;

    always_comb begin
        if (locked) begin
            gnt_vld = IN_VALID[lock_ch];
            gnt     = lock_ch;
        end else begin
            gnt_vld = MODE ? fp_vld : rr_vld;
            gnt     = MODE ? fp_gnt : rr_gnt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            locked  <= !IN_LAST[gnt];
            lock_ch <= gnt;
        end
    end
`else
    always_comb begin
        gnt_vld = MODE ? fp_vld : rr_vld;
        gnt     = MODE ? fp_gnt : rr_gnt;
    end
`endif

    assign load_en = !OUT_VALID || OUT_READY;
    assign xfer    = RST_N && gnt_vld && load_en;
    assign gnt_dat = IN_DATA[gnt*N +: N];
    assign ptr_nxt = (gnt == SW'(CH - 1)) ? '0 : gnt + 1'b1;

    always_comb begin
        IN_READY = '0;
        if (xfer)
            IN_READY[gnt] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_DATA  <= '0;
            OUT_SEL   <= '0;
            OUT_VALID <= 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            OUT_LAST  <= 1'b0;
`endif
        end else if (load_en) begin
            if (xfer) begin
                OUT_DATA  <= gnt_dat;
                OUT_SEL   <= gnt;
                OUT_VALID <= 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
                OUT_LAST  <= IN_LAST[gnt];
`endif
            end else begin
                OUT_VALID <= 1'b0;
            end
        end
    end

    // With packet lock the pointer only moves past a channel once its packet ends.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (xfer) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
            if (IN_LAST[gnt])
                ptr <= ptr_nxt;
`else
            ptr <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized scoreboard bench for stream_mux_rr: a queue-based reference model predicts grants and beats.
module tb_stream_mux_rr;
    localparam int N  = 4;
    localparam int CH = 4;
    localparam int SW = 2;
    localparam logic [CH*N-1:0] ABCD = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            MODE = 1'b0;
    logic [CH*N-1:0] IN_DATA = '0;
    logic [CH-1:0]   IN_VALID = '0;
    logic [CH-1:0]   IN_READY;
    logic [CH-1:0]   IN_LAST = '1;
    logic [N-1:0]    OUT_DATA;
    logic            OUT_VALID;
    logic            OUT_READY = 1'b0;
    logic [SW-1:0]   OUT_SEL;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            OUT_LAST;
`endif

    stream_mux_rr #(.N(N), .CH(CH)) dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .IN_LAST(IN_LAST), .OUT_LAST(OUT_LAST),
`endif
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SEL(OUT_SEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0] dat;
        int           sel;
        logic         last;
    } beat_t;

    beat_t sbq[$];
    int    total = 0;
    int    bad = 0;

    int    m_ptr = 0;
    bit    m_full = 0;
    bit    m_locked = 0;
    int    m_lock_ch = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        m_ptr = 0;
        m_full = 0;
        m_locked = 0;
        m_lock_ch = 0;
    endtask

    // One clock of stimulus; the model decides who should win from the arbitration rules.
    task automatic cycle(input logic [CH-1:0] v, input logic [CH*N-1:0] d, input logic rdy,
                         input logic md, input logic [CH-1:0] lst);
        int           w;
        int           best;
        bit           load_en;
        logic [CH-1:0] exp_rdy;
        beat_t        b;
        @(negedge CLK);
        IN_VALID  = v;
        IN_DATA   = d;
        OUT_READY = rdy;
        MODE      = md;
        IN_LAST   = lst;
        #1;
        check("out_valid", int'(OUT_VALID), int'(m_full));
        load_en = !m_full || rdy;
        w = -1;
        if (m_locked) begin
            if (v[m_lock_ch]) w = m_lock_ch;
        end else if (md) begin
            for (int k = CH - 1; k >= 0; k--)
                if (v[k]) w = k;
        end else begin
            best = CH;
            for (int k = 0; k < CH; k++)
                if (v[k] && ((k - m_ptr + CH) % CH) < best) begin
                    best = (k - m_ptr + CH) % CH;
                    w = k;
                end
        end
        exp_rdy = '0;
        if (w >= 0 && load_en) exp_rdy[w] = 1'b1;
        check("in_ready", int'(IN_READY), int'(exp_rdy));
        if (load_en) begin
            if (w >= 0) begin
                b.dat = d[w*N +: N];
                b.sel = w;
`ifdef STREAM_MUX_PKT_LOCK_EN
                b.last    = lst[w];
                m_locked  = !lst[w];
                m_lock_ch = w;
                if (lst[w]) m_ptr = (w + 1) % CH;
`else
                b.last = 1'b1;
                m_ptr  = (w + 1) % CH;
`endif
                sbq.push_back(b);
                m_full = 1;
            end else begin
                m_full = 0;
            end
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_out_valid"}, int'(OUT_VALID), 0);
        check({tag, "_out_data"}, int'(OUT_DATA), 0);
        check({tag, "_out_sel"}, int'(OUT_SEL), 0);
        check({tag, "_in_ready"}, int'(IN_READY), 0);
    endtask

    task automatic mid_reset();
        @(negedge CLK);
        IN_VALID = '1;
        RST_N = 1'b0;
        #1;
        reset_check("mid_rst");
        model_reset();
        @(negedge CLK);
        IN_VALID = '0;
        RST_N = 1'b1;
    endtask

    // Monitor: pops on every output handshake, sampled just before the edge that completes it.
    initial begin
        beat_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (RST_N && OUT_VALID && OUT_READY) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty actual=beat required=none at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", int'(OUT_DATA), int'(e.dat));
                    check("out_sel", int'(OUT_SEL), e.sel);
`ifdef STREAM_MUX_PKT_LOCK_EN
                    check("out_last", int'(OUT_LAST), int'(e.last));
`endif
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] rl;
        RST_N = 1'b0;
        IN_VALID = '1;
        IN_DATA = ABCD;
        OUT_READY = 1'b1;
        #12;
        reset_check("rst");
        model_reset();
        @(negedge CLK);
        IN_VALID = '0;
        RST_N = 1'b1;

        repeat (8) cycle('1, ABCD, 1'b1, 1'b0, '1);
        repeat (4) cycle(4'b1110, ABCD, 1'b1, 1'b1, '1);
        repeat (3) cycle(4'b1100, ABCD, 1'b1, 1'b1, '1);
        cycle('1, ABCD, 1'b1, 1'b0, '1);
        repeat (3) cycle('1, ABCD, 1'b0, 1'b0, '1);
        repeat (4) cycle('1, ABCD, 1'b1, 1'b0, '1);

        mid_reset();
        cycle(4'b0100, ABCD, 1'b1, 1'b0, '1);
        repeat (2) cycle(4'b0101, ABCD, 1'b1, 1'b0, '1);
        repeat (3) cycle(4'b0000, ABCD, 1'b1, 1'b0, '1);

        mid_reset();
        cycle(4'b0010, ABCD, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0111, ABCD, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0111, ABCD, 1'b1, 1'b0, 4'b0010);
        cycle(4'b0101, ABCD, 1'b1, 1'b0, 4'b1111);

        repeat (3000) begin
            rl = CH'($urandom) | CH'($urandom);
            cycle(CH'($urandom), (CH*N)'($urandom), ($urandom % 4) != 0, 1'($urandom), rl);
        end
        mid_reset();
        repeat (500) begin
            rl = CH'($urandom) | CH'($urandom);
            cycle(CH'($urandom), (CH*N)'($urandom), ($urandom % 3) != 0, 1'($urandom), rl);
        end
        repeat (4) cycle('0, '0, 1'b1, 1'b0, '1);
        check("drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
